// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and result-buffer entry layout.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned FLAG_W  = 3;
  // Entry layout is {y, sel, flags}
  localparam int unsigned ENTRY_W = DATA_W + SEL_W + FLAG_W;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic circular-buffer FIFO with wrap-bit pointers; occupancy is the pointer difference.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 39
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty   = (wptr_q == rptr_q);
  assign count   = wptr_q - rptr_q;
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage has no reset; entries are only visible through valid pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_result_buf.sv
// ALU result buffer: derives {N,Z,C}, queues entries, keeps sticky flags.
// Optional saturating statistics counters when ALU_RESULT_BUF_STATS_EN is defined.
module alu_result_buf
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_y,
  input  logic                   in_cout,
  input  logic [3:0]             in_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [3:0]             out_sel,
  output logic [2:0]             out_flags,
  output logic [$clog2(DEPTH):0] count,
`ifdef ALU_RESULT_BUF_STATS_EN
  input  logic                   stats_clr,
  output logic [15:0]            stat_push,
  output logic [15:0]            stat_stall,
  output logic [15:0]            stat_full,
`endif
  output logic [2:0]             sticky_flags,
  input  logic                   clr_sticky
);

  localparam int unsigned EW = WIDTH + SEL_W + FLAG_W;

  logic              full, empty, push, pop;
  logic [2:0]        in_flags;
  logic [EW-1:0]     head;
  logic [2:0]        sticky_q, sticky_d;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_C] = (in_sel[3:2] == OP_ADD[3:2]) ? in_cout : 1'b0;
    in_flags[FLAG_Z] = (in_y == '0);
    in_flags[FLAG_N] = in_y[WIDTH-1];
  end

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_y, in_sel, in_flags}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {out_y, out_sel, out_flags} = out_valid ? head : '0;

  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = push ? in_flags : '0;
    end else if (push) begin
      sticky_d = sticky_q | in_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;

`ifdef ALU_RESULT_BUF_STATS_EN
  logic [15:0] stat_push_q, stat_push_d;
  logic [15:0] stat_stall_q, stat_stall_d;
  logic [15:0] stat_full_q, stat_full_d;

  always_comb begin
    stat_push_d  = stat_push_q;
    stat_stall_d = stat_stall_q;
    stat_full_d  = stat_full_q;
    if (stats_clr) begin
      stat_push_d  = '0;
      stat_stall_d = '0;
      stat_full_d  = '0;
    end else begin
      if (push && stat_push_q != '1)                     stat_push_d  = stat_push_q + 1'b1;
      if (out_valid && !out_ready && stat_stall_q != '1) stat_stall_d = stat_stall_q + 1'b1;
      if (in_valid && !in_ready && stat_full_q != '1)    stat_full_d  = stat_full_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_push_q  <= '0;
      stat_stall_q <= '0;
      stat_full_q  <= '0;
    end else begin
      stat_push_q  <= stat_push_d;
      stat_stall_q <= stat_stall_d;
      stat_full_q  <= stat_full_d;
    end
  end

  assign stat_push  = stat_push_q;
  assign stat_stall = stat_stall_q;
  assign stat_full  = stat_full_q;
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed self-checking bench for alu_result_buf (DEPTH=4, WIDTH=32).
module tb_alu_result_buf;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cout;
  logic [31:0] in_y;
  logic [3:0]  in_sel;
  logic        out_valid, out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_sel;
  logic [2:0]  out_flags, sticky_flags;
  logic [2:0]  count;
  logic        clr_sticky;
`ifdef ALU_RESULT_BUF_STATS_EN
  logic        stats_clr;
  logic [15:0] stat_push, stat_stall, stat_full;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_buf #(
    .DEPTH (4),
    .WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_cout      (in_cout),
    .in_sel       (in_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_sel      (out_sel),
    .out_flags    (out_flags),
    .count        (count),
`ifdef ALU_RESULT_BUF_STATS_EN
    .stats_clr    (stats_clr),
    .stat_push    (stat_push),
    .stat_stall   (stat_stall),
    .stat_full    (stat_full),
`endif
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] sel, input logic [31:0] y, input logic c);
    in_valid = v;
    in_sel   = sel;
    in_y     = y;
    in_cout  = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
`ifdef ALU_RESULT_BUF_STATS_EN
    stats_clr  = 1'b0;
`endif
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    #5 rst = 1'b0;

    // single ADD of zero with carry
    drive(1'b1, OP_ADD, 32'h0, 1'b1);
    step();
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_flags", 64'(out_flags), 64'b011);
    check("t1_sticky", 64'(sticky_flags), 64'b011);
    check("t1_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_drained", 64'(count), 64'd0);
    check("t1_empty", 64'(out_valid), 64'd0);

    // bus activity without in_valid is not a push
    drive(1'b0, OP_OR, 32'h55, 1'b1);
    step();
    check("novalid_count", 64'(count), 64'd0);

    // fill
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, OP_OR, 32'(i), 1'b0);
      step();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, OP_OR, 32'd99, 1'b0);
    step();
    check("fill_fifth_ignored", 64'(count), 64'd4);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_y%0d", i), 64'(out_y), 64'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_empty", 64'(out_valid), 64'd0);

    // sustained push+pop at count=2 across pointer wraps
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, OP_XOR, 32'(100 + i), 1'b0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, OP_XOR, 32'(102 + i), 1'b0);
      check($sformatf("sust_y%0d", i), 64'(out_y), 64'(100 + i));
      step();
      check($sformatf("sust_count%0d", i), 64'(count), 64'd2);
    end
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    check("sust_tail0", 64'(out_y), 64'd110);
    step();
    check("sust_tail1", 64'(out_y), 64'd111);
    step();
    out_ready = 1'b0;
    check("sust_empty", 64'(count), 64'd0);

    // flag derivation
    drive(1'b1, OP_AND, 32'h8000_0000, 1'b1);
    step();
    check("and_flags", 64'(out_flags), 64'b100);
    drive(1'b1, OP_SUB, 32'hFFFF_FFFF, 1'b1);
    out_ready = 1'b1;
    step();
    check("sub_flags", 64'(out_flags), 64'b101);
    check("sub_sel", 64'(out_sel), 64'(OP_SUB));
    drive(1'b1, 4'b1100, 32'h7, 1'b1);
    step();
    check("hiop_sel", 64'(out_sel), 64'hC);
    check("hiop_flags", 64'(out_flags), 64'b000);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    out_ready = 1'b0;
    check("flags_empty", 64'(count), 64'd0);
    check("flags_masked", 64'(out_flags), 64'd0);

    // sticky flags
    check("sticky_accum", 64'(sticky_flags), 64'b111);
    clr_sticky = 1'b1;
    drive(1'b1, OP_XOR, 32'd5, 1'b0);
    step();
    check("clr_push_y5", 64'(sticky_flags), 64'b000);
    clr_sticky = 1'b0;
    drive(1'b1, OP_OR, 32'h8000_0000, 1'b0);
    step();
    check("sticky_n", 64'(sticky_flags), 64'b100);
    clr_sticky = 1'b1;
    drive(1'b1, OP_ADD, 32'h0, 1'b0);
    step();
    check("clr_push_zero", 64'(sticky_flags), 64'b010);
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    step();
    clr_sticky = 1'b0;
    check("clr_alone", 64'(sticky_flags), 64'b000);
    check("sticky_count", 64'(count), 64'd3);

    // asynchronous reset with 3 entries queued
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_y", 64'(out_y), 64'd0);
    #1 rst = 1'b0;
    step();
    check("post_rst_count", 64'(count), 64'd0);

`ifdef ALU_RESULT_BUF_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("stat_clr", 64'(stat_stall), 64'd0);
    drive(1'b1, OP_ADD, 32'h1, 1'b0);
    step();
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    check("stat_push1", 64'(stat_push), 64'd1);
    repeat (70000) @(posedge clk);
    #1;
    check("stat_stall_sat", 64'(stat_stall), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
